// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             op_sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;

  modport master (
    output start, a_in, b_in, c_in, op_sub,
    input  busy, done, sum, co
  );

  modport slave (
    input  start, a_in, b_in, c_in, op_sub,
    output busy, done, sum, co
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus carry flop, LSB first.
// Optional subtract mode is enabled by defining SERIAL_SUB_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res, res_next, sum_q;
  logic [WIDTH-1:0] b_load;
  logic [CW-1:0]    cnt;
  logic             carry, carry_next, carry_load, s, co_q;
  logic             accept, last;

`ifdef SERIAL_SUB_EN
  // Subtract as a + ~b + 1: invert B and force the initial carry.
  always_comb begin
    b_load     = bus.op_sub ? ~bus.b_in : bus.b_in;
    carry_load = bus.op_sub ? 1'b1 : bus.c_in;
  end
`else
  logic op_sub_unused;
  assign op_sub_unused = bus.op_sub;

  always_comb begin
    b_load     = bus.b_in;
    carry_load = bus.c_in;
  end
`endif

  always_comb begin
    accept     = bus.start && ((state == IDLE) || (state == DONE));
    last       = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    s          = a_sr[0] ^ b_sr[0] ^ carry;
    carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    // New bit enters at the MSB; the WIDTH+1 wide shift also covers WIDTH=1.
    res_next   = WIDTH'({s, res} >> 1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last) state_next = DONE;
      DONE:    state_next = bus.start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum_q <= '0;
      co_q  <= 1'b0;
    end else if (accept) begin
      a_sr  <= bus.a_in;
      b_sr  <= b_load;
      res   <= '0;
      carry <= carry_load;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      res   <= res_next;
      carry <= carry_next;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum_q <= res_next;
        co_q  <= carry_next;
      end
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.co   = co_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder (WIDTH=8 and WIDTH=1) against an arithmetic model.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] exp_sum, pend_sum;
  logic       exp_co, pend_co;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b,
                                        input logic c, input logic sub);
    int unsigned t;
    t = 32'(a) + 32'(b) + 32'(c);
`ifdef SERIAL_SUB_EN
    if (sub) t = 32'(a) + 32'(8'hFF - b) + 32'd1;
`endif
    return t[8:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call just after a negedge; returns just after the accepting posedge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sub);
    bus8.a_in   = a;
    bus8.b_in   = b;
    bus8.c_in   = c;
    bus8.op_sub = sub;
    bus8.start  = 1'b1;
    {pend_co, pend_sum} = model8(a, b, c, sub);
    @(posedge clk);
  endtask

  // Returns at the negedge of the done cycle; start is kept high with junk for `hold` cycles.
  task automatic wait_done(input string tag, input int hold);
    int k_done = -1;
    int busy_n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus8.done) begin
        k_done = k;
        break;
      end
      if (bus8.busy) busy_n++;
      chk({tag, "_sum_stable"}, 32'(bus8.sum), 32'(exp_sum));
      if (k < hold) begin
        bus8.start  = 1'b1;
        bus8.a_in   = 8'($urandom);
        bus8.b_in   = 8'($urandom);
        bus8.c_in   = 1'($urandom);
        bus8.op_sub = 1'($urandom);
      end else begin
        bus8.start = 1'b0;
      end
    end
    bus8.start = 1'b0;
    chk({tag, "_latency"}, 32'(k_done), 32'd8);
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
    exp_sum = pend_sum;
    exp_co  = pend_co;
    chk({tag, "_sum"}, 32'(bus8.sum), 32'(exp_sum));
    chk({tag, "_co"}, 32'(bus8.co), 32'(exp_co));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.c_in = 1'b0; bus8.op_sub = 1'b0;
    bus1.start = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.c_in = 1'b0; bus1.op_sub = 1'b0;
    exp_sum = '0; exp_co = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_done", 32'(bus8.done), 32'd0);
    chk("rst_sum", 32'(bus8.sum), 32'd0);
    chk("rst_co", 32'(bus8.co), 32'd0);
    rst_n = 1'b1;

    // Zero operands, then done must drop after one cycle.
    @(negedge clk);
    issue(8'h00, 8'h00, 1'b0, 1'b0);
    wait_done("zero", 0);
    @(negedge clk);
    chk("zero_done_pulse", 32'(bus8.done), 32'd0);
    chk("zero_idle_busy", 32'(bus8.busy), 32'd0);

    // Overflow wrap, then back-to-back issue on the done cycle.
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done("wrap", 0);
    chk("wrap_sum_const", 32'(bus8.sum), 32'h00);
    chk("wrap_co_const", 32'(bus8.co), 32'd1);
    issue(8'hA5, 8'h5A, 1'b1, 1'b0);
    wait_done("b2b", 0);
    chk("b2b_sum_const", 32'(bus8.sum), 32'h00);
    chk("b2b_co_const", 32'(bus8.co), 32'd1);

    // start held during SHIFT with other operands must be ignored.
    @(negedge clk);
    issue(8'h3C, 8'h0F, 1'b1, 1'b0);
    wait_done("hold", 7);
    chk("hold_sum_const", 32'(bus8.sum), 32'h4C);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_single_done", 32'(bus8.done), 32'd0);
      chk("hold_idle", 32'(bus8.busy), 32'd0);
    end

    // Asynchronous reset in the middle of an operation.
    issue(8'h77, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus8.busy), 32'd0);
    chk("midrst_done", 32'(bus8.done), 32'd0);
    chk("midrst_sum", 32'(bus8.sum), 32'd0);
    chk("midrst_co", 32'(bus8.co), 32'd0);
    exp_sum = '0; exp_co = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(bus8.done), 32'd0);
    end
    issue(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    wait_done("after_rst", 0);

    // WIDTH=1 full-adder truth table sweep, issued back-to-back.
    @(negedge clk);
    for (int v = 0; v < 8; v++) begin
      logic [2:0] abc;
      logic [1:0] fa;
      abc = 3'(v);
      fa  = 2'(abc[2]) + 2'(abc[1]) + 2'(abc[0]);
      bus1.a_in  = abc[2];
      bus1.b_in  = abc[1];
      bus1.c_in  = abc[0];
      bus1.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.start = 1'b0;
      chk("w1_busy", 32'(bus1.busy), 32'd1);
      chk("w1_not_done", 32'(bus1.done), 32'd0);
      @(negedge clk);
      chk("w1_done", 32'(bus1.done), 32'd1);
      chk("w1_sum", 32'(bus1.sum), 32'(fa[0]));
      chk("w1_co", 32'(bus1.co), 32'(fa[1]));
    end
    @(negedge clk);

    // Subtract select: only effective when the feature is built in.
    issue(8'h10, 8'h01, 1'b0, 1'b1);
    wait_done("sub1", 0);
`ifdef SERIAL_SUB_EN
    chk("sub1_sum_const", 32'(bus8.sum), 32'h0F);
    chk("sub1_co_const", 32'(bus8.co), 32'd1);
`else
    chk("sub1_sum_const", 32'(bus8.sum), 32'h11);
    chk("sub1_co_const", 32'(bus8.co), 32'd0);
`endif
    @(negedge clk);
    issue(8'h01, 8'h02, 1'b0, 1'b1);
    wait_done("sub2", 0);
`ifdef SERIAL_SUB_EN
    chk("sub2_sum_const", 32'(bus8.sum), 32'hFF);
    chk("sub2_co_const", 32'(bus8.co), 32'd0);
`else
    chk("sub2_sum_const", 32'(bus8.sum), 32'h03);
    chk("sub2_co_const", 32'(bus8.co), 32'd0);
`endif

    // Random operations with random gaps or back-to-back issue.
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      issue(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      wait_done("rand", 0);
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
